// File: rtl/read_stream_cmd_scheduler.sv
// Streams a strided read job as 128-byte-aligned read commands, gated by a
// returning-credit counter, and pulses done once every credit is back.
module read_stream_cmd_scheduler #(
    parameter int unsigned ARRAY_SIZE      = 4,
    parameter int unsigned ARRAY_SIZE_BITS = 32,
    parameter int unsigned CREDITS         = 16
) (
    input  logic                       clock,
    input  logic                       rstn,
    input  logic                       enabled,
    input  logic                       cfg_valid,
    input  logic [63:0]                cfg_addr,
    input  logic [ARRAY_SIZE_BITS-1:0] cfg_count,
    input  logic                       credit_in,
    input  logic                       cmd_ready,
    output logic                       cmd_valid,
    output logic [63:0]                cmd_addr,
    output logic [11:0]                cmd_size,
    output logic [7:0]                 cmd_tag,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned SHIFT   = $clog2(ARRAY_SIZE);
    localparam int unsigned BYTES_W = ARRAY_SIZE_BITS + 8;
    localparam logic [ARRAY_SIZE_BITS-1:0] ELEMS_PER_CMD = ARRAY_SIZE_BITS'(128 / ARRAY_SIZE);
    localparam logic [7:0] CREDIT_FULL = 8'(CREDITS);

    typedef enum logic [2:0] {
        S_RESET,
        S_IDLE,
        S_SET,
        S_START,
        S_FINAL
    } state_t;

    state_t                     state_q, state_d;
    logic [ARRAY_SIZE_BITS-1:0] remaining_q, remaining_d;
    logic [7:0]                 credits_q, credits_d;
    logic                       cmd_valid_d;
    logic [63:0]                cmd_addr_d;
    logic [11:0]                cmd_size_d;
    logic [7:0]                 cmd_tag_d;
    logic                       busy_d;
    logic                       done_d;
    logic                       accept;
    logic                       credit_ret;
    logic [ARRAY_SIZE_BITS-1:0] step;
    logic                       unused_addr_lsbs;

    // Job addresses are line aligned; the low address bits are dropped.
    assign unused_addr_lsbs = ^cfg_addr[6:0];

    // 0 for an empty remainder, 128 when a full line remains, else next power of two.
    function automatic logic [11:0] size_of(input logic [ARRAY_SIZE_BITS-1:0] rem);
        logic [BYTES_W-1:0] bytes;
        logic [11:0]        sz;
        bytes = BYTES_W'(rem) << SHIFT;
        sz    = 12'd0;
        if (bytes > BYTES_W'(128)) begin
            sz = 12'd128;
        end else if (bytes != '0) begin
            for (int i = 7; i >= 0; i--) begin
                if (bytes <= (BYTES_W'(1) << i)) begin
                    sz = 12'(1) << i;
                end
            end
        end
        return sz;
    endfunction

    assign accept     = cmd_valid & cmd_ready;
    assign credit_ret = credit_in && (credits_q != CREDIT_FULL);
    assign step       = (remaining_q < ELEMS_PER_CMD) ? remaining_q : ELEMS_PER_CMD;

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        credits_d   = credits_q - 8'(accept) + 8'(credit_ret);
        cmd_valid_d = cmd_valid;
        cmd_addr_d  = cmd_addr;
        cmd_size_d  = cmd_size;
        cmd_tag_d   = cmd_tag;
        done_d      = 1'b0;

        if (accept) begin
            remaining_d = remaining_q - step;
            cmd_addr_d  = cmd_addr + 64'd128;
            cmd_tag_d   = cmd_tag + 8'd1;
            cmd_valid_d = 1'b0;
        end

        case (state_q)
            S_RESET: state_d = S_IDLE;
            S_IDLE: begin
                if (enabled && cfg_valid) begin
                    cmd_addr_d  = {cfg_addr[63:7], 7'b0};
                    remaining_d = cfg_count;
                    cmd_tag_d   = 8'd0;
                    state_d     = S_SET;
                end
            end
            S_SET: state_d = (remaining_q == '0) ? S_FINAL : S_START;
            S_START: begin
                // A presented command is only replaced once it has been taken.
                if (!cmd_valid || accept) begin
                    if (remaining_d == '0) begin
                        state_d = S_FINAL;
                    end else if (enabled && credits_d != 8'd0) begin
                        cmd_valid_d = 1'b1;
                        cmd_size_d  = size_of(remaining_d);
                    end
                end
            end
            S_FINAL: begin
                if (credits_q == CREDIT_FULL) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_RESET;
        endcase

        busy_d = (state_d != S_IDLE) && (state_d != S_RESET);
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_RESET;
            remaining_q <= '0;
            credits_q   <= CREDIT_FULL;
            cmd_valid   <= 1'b0;
            cmd_addr    <= 64'd0;
            cmd_size    <= 12'd0;
            cmd_tag     <= 8'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            credits_q   <= credits_d;
            cmd_valid   <= cmd_valid_d;
            cmd_addr    <= cmd_addr_d;
            cmd_size    <= cmd_size_d;
            cmd_tag     <= cmd_tag_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

endmodule

// File: doc/read_stream_cmd_scheduler.md
READ_STREAM_CMD_SCHEDULER -- requirements
Module: read_stream_cmd_scheduler

Interface
REQ-001 SHALL have parameter ARRAY_SIZE, default 4: bytes per element; power of two, 1..128.
REQ-002 SHALL have parameter ARRAY_SIZE_BITS, default 32: width of element-count fields.
REQ-003 SHALL have parameter CREDITS, default 16: maximum outstanding read commands; 1..255.
REQ-004 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enabled  input  1  permits configuration acceptance and new command issue.
REQ-007 SHALL have port cfg_valid  input  1  job descriptor present.
REQ-008 SHALL have port cfg_addr  input  64  job base byte address.
REQ-009 SHALL have port cfg_count  input  ARRAY_SIZE_BITS  job length in elements.
REQ-010 SHALL have port credit_in  input  1  one read response retired (one credit returned).
REQ-011 SHALL have port cmd_ready  input  1  downstream accepts a command.
REQ-012 SHALL have port cmd_valid  output  1  command presented.
REQ-013 SHALL have port cmd_addr  output  64  command byte address.
REQ-014 SHALL have port cmd_size  output  12  command size in bytes: 0, 1, 2, 4, ..., 128.
REQ-015 SHALL have port cmd_tag  output  8  command tag.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE and RESET.
REQ-017 SHALL have port done  output  1  one-cycle job-complete pulse.

Function
REQ-018 SHALL implement states RESET, IDLE, SET, START and FINAL.
REQ-019 SHALL move RESET->IDLE on the first clock after rstn deasserts.
REQ-020 SHALL accept a job only in IDLE with enabled=1 and cfg_valid=1, latch the address with bits [6:0] forced to zero and latch the count, then enter SET; cfg_valid outside IDLE SHALL be ignored.
REQ-021 In SET, SHALL enter FINAL if the remaining count is 0, else START; the first cmd_valid appears 2 cycles after job acceptance.
REQ-022 Command size: remaining bytes = remaining elements << log2(ARRAY_SIZE); >128 bytes gives 128; otherwise the smallest power of two >= remaining bytes; 0 bytes gives 0.
REQ-023 Each accepted command (cmd_valid & cmd_ready) SHALL:
  - subtract min(remaining, 128/ARRAY_SIZE) from the remaining count;
  - advance the address by 128;
  - increment cmd_tag modulo 256.
REQ-024 cmd_tag SHALL start at 0 for every job.
REQ-025 SHALL hold cmd_valid, cmd_addr, cmd_size and cmd_tag stable while cmd_valid=1 and cmd_ready=0; enabled=0 SHALL NOT withdraw a command already presented.
REQ-026 SHALL assert a new cmd_valid only in START, with enabled=1, remaining count >0 and credit counter >0.
REQ-027 Credit counter SHALL decrement on command acceptance and increment on credit_in; both in one cycle SHALL leave it unchanged.
REQ-028 credit_in while the counter equals CREDITS SHALL be ignored.
REQ-029 SHALL move START->FINAL when the remaining count is 0 and no command is pending.
REQ-030 SHALL leave FINAL for IDLE once the credit counter equals CREDITS, asserting done for exactly that one cycle.
REQ-031 Back-to-back commands SHALL be possible at one per cycle while cmd_ready=1 and credits remain.

Reset
REQ-032 On rstn=0, SHALL asynchronously enter RESET with these values: cmd_valid=0, cmd_addr=0, cmd_size=0, cmd_tag=0, busy=0, done=0, credit counter=CREDITS, remaining count=0.
REQ-033 Reset mid-job SHALL abandon the job completely; nothing carries over to the next job.

Verification
REQ-034 ARRAY_SIZE=4, cfg_addr=0x1000, cfg_count=64, cmd_ready=1 -> cmds (0x1000,128,tag0),(0x1080,128,tag1); done 1 cycle after 2nd credit_in.
REQ-035 cfg_count=5, cfg_addr=0x2045 -> single cmd (0x2000,32,tag0); done after 1 credit.
REQ-036 cfg_count=0 -> no cmd_valid, done pulse 2 cycles after acceptance, busy high for those cycles.
REQ-037 CREDITS=2, cfg_count=128 -> exactly 2 cmds then cmd_valid=0; each credit_in releases one more cmd; 4 cmds total, done after 4th credit.
REQ-038 cmd_ready=0 for 5 cycles with cmd_valid=1 -> all cmd fields constant; enabled toggled low meanwhile -> cmd_valid stays 1.
REQ-039 rstn pulled low after 1st of 4 cmds -> outputs at reset values immediately; new job with cfg_count=32 -> single cmd with tag 0, credits full.
